// File: rtl/video_pkg.sv
// Shared constants for the Spectrum video path: XGA raster timing and the Spectrum screen geometry.
// The pixel/attribute fetch stage imports the same geometry constants.
package video_pkg;

    localparam int unsigned CNT_W        = 11;

    localparam int unsigned XGA_H_ACTIVE = 1024;
    localparam int unsigned XGA_H_FP     = 24;
    localparam int unsigned XGA_H_SYNC   = 136;
    localparam int unsigned XGA_H_BP     = 160;
    localparam int unsigned XGA_V_ACTIVE = 768;
    localparam int unsigned XGA_V_FP     = 3;
    localparam int unsigned XGA_V_SYNC   = 6;
    localparam int unsigned XGA_V_BP     = 29;

    localparam int unsigned XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
    localparam int unsigned XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

    localparam int unsigned SPEC_H_PIX   = 256;
    localparam int unsigned SPEC_V_PIX   = 192;
    localparam int unsigned SPEC_SCALE   = 4;

    localparam int unsigned FLASH_DIV_W  = 4;

    function automatic logic sync_level(input logic pol, input logic active);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/video_flash_div.sv
// Spectrum FLASH divider: 4-bit frame counter, output toggles every 16 frames (32-frame period).
// Output is registered and changes only on the edge that presents a tick.
module video_flash_div
    import video_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    output logic o_flash
);

    logic [FLASH_DIV_W-1:0] r_cnt;
    logic                   r_armed;
    logic                   r_flash;

    // The first tick after reset is the start of frame 0 itself, so it only arms the counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_flash <= 1'b0;
        end else if (i_tick) begin
            if (!r_armed) begin
                r_armed <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (&r_cnt)
                    r_flash <= ~r_flash;
            end
        end
    end

    assign o_flash = r_flash;

endmodule

// File: rtl/video_timing.sv
// Raster timing generator (XGA 1024x768@60 by default) with registered, zero-skew sync/de/frame strobes.
// Optional FLASH divider built only when VIDEO_TIMING_FLASH_EN is defined; otherwise o_flash is tied low.
module video_timing
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = XGA_H_ACTIVE,
    parameter int unsigned H_FP     = XGA_H_FP,
    parameter int unsigned H_SYNC   = XGA_H_SYNC,
    parameter int unsigned H_BP     = XGA_H_BP,
    parameter int unsigned V_ACTIVE = XGA_V_ACTIVE,
    parameter int unsigned V_FP     = XGA_V_FP,
    parameter int unsigned V_SYNC   = XGA_V_SYNC,
    parameter int unsigned V_BP     = XGA_V_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    output logic [CNT_W-1:0] o_hcnt,
    output logic [CNT_W-1:0] o_vcnt,
    output logic             o_de,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_frame_start,
    output logic             o_flash
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_params
        $error("video_timing: raster total exceeds the 11-bit counters");
    end

    localparam logic [CNT_W-1:0] L_H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] L_V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] L_H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] L_V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] L_HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] L_HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] L_VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] L_VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_hcnt, r_vcnt;
    logic             r_de, r_hsync, r_vsync, r_frame_start;
    logic [CNT_W-1:0] w_h_next, w_v_next;
    logic             w_fs_next;

    // Decode from the next counter values so every registered output lines up with the counters.
    always_comb begin
        w_h_next = r_hcnt + 1'b1;
        w_v_next = r_vcnt;
        if (r_hcnt == L_H_LAST) begin
            w_h_next = '0;
            w_v_next = (r_vcnt == L_V_LAST) ? '0 : r_vcnt + 1'b1;
        end
        w_fs_next = (w_h_next == '0) && (w_v_next == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hcnt        <= L_H_LAST;
            r_vcnt        <= L_V_LAST;
            r_de          <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_hcnt        <= w_h_next;
            r_vcnt        <= w_v_next;
            r_de          <= (w_h_next < L_H_ACT) && (w_v_next < L_V_ACT);
            r_hsync       <= sync_level(SYNC_POL, (w_h_next >= L_HS_BEG) && (w_h_next < L_HS_END));
            r_vsync       <= sync_level(SYNC_POL, (w_v_next >= L_VS_BEG) && (w_v_next < L_VS_END));
            r_frame_start <= w_fs_next;
        end
    end

    assign o_hcnt        = r_hcnt;
    assign o_vcnt        = r_vcnt;
    assign o_de          = r_de;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_frame_start = r_frame_start;

`ifdef VIDEO_TIMING_FLASH_EN
    video_flash_div u_flash (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_tick  (w_fs_next),
        .o_flash (o_flash)
    );
`else
    assign o_flash = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: XGA instance checked against a directed vector table, plus a
// reduced-raster instance checked cycle by cycle against a reference model (frames, vsync, FLASH).
module tb_video_timing;

    logic        clk = 1'b0;
    logic        rst_x, rst_s;
    logic [10:0] x_h, x_v, s_h, s_v;
    logic        x_de, x_hs, x_vs, x_fs, x_fl;
    logic        s_de, s_hs, s_vs, s_fs, s_fl;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    video_timing u_xga (
        .i_clk(clk), .i_reset(rst_x), .o_hcnt(x_h), .o_vcnt(x_v), .o_de(x_de),
        .o_hsync(x_hs), .o_vsync(x_vs), .o_frame_start(x_fs), .o_flash(x_fl)
    );

    // Reduced raster: H_TOTAL 16 (hsync 10..12), V_TOTAL 10 (vsync lines 7..8), 160 clocks per frame.
    video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) u_sm (
        .i_clk(clk), .i_reset(rst_s), .o_hcnt(s_h), .o_vcnt(s_v), .o_de(s_de),
        .o_hsync(s_hs), .o_vsync(s_vs), .o_frame_start(s_fs), .o_flash(s_fl)
    );

    typedef struct {
        int c;
        int h;
        int v;
        bit de;
        bit hs;
        bit vs;
        bit fs;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int exp_flash(input int frame);
`ifdef VIDEO_TIMING_FLASH_EN
        return (frame / 16) % 2;
`else
        return 0;
`endif
    endfunction

    task automatic chk_x(input string tag, input int h, input int v, input int de,
                         input int hs, input int vs, input int fs);
        chk({tag, "_hcnt"}, int'(x_h), h);
        chk({tag, "_vcnt"}, int'(x_v), v);
        chk({tag, "_de"}, int'(x_de), de);
        chk({tag, "_hsync"}, int'(x_hs), hs);
        chk({tag, "_vsync"}, int'(x_vs), vs);
        chk({tag, "_fs"}, int'(x_fs), fs);
        chk({tag, "_flash"}, int'(x_fl), 0);
    endtask

    // Independent model of the reduced raster, compared every cycle from the first post-reset cycle.
    task automatic run_small(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            int h, v, f;
            string t;
            @(negedge clk);
            h = c % 16;
            v = (c / 16) % 10;
            f = c / 160;
            t = $sformatf("%s@%0d", tag, c);
            chk({t, "_hcnt"}, int'(s_h), h);
            chk({t, "_vcnt"}, int'(s_v), v);
            chk({t, "_de"}, int'(s_de), int'(h < 8 && v < 6));
            chk({t, "_hsync"}, int'(s_hs), int'(!(h >= 10 && h < 13)));
            chk({t, "_vsync"}, int'(s_vs), int'(!(v >= 7 && v < 9)));
            chk({t, "_fs"}, int'(s_fs), int'(c % 160 == 0));
            chk({t, "_flash"}, int'(s_fl), exp_flash(f));
        end
    endtask

    initial begin
        int idx, de_cnt, hs_cnt, hs_first, hs_last;

        //          c     h     v   de hs vs fs
        tbl[0]  = '{0,    0,    0,  1, 1, 1, 1};
        tbl[1]  = '{1,    1,    0,  1, 1, 1, 0};
        tbl[2]  = '{1023, 1023, 0,  1, 1, 1, 0};
        tbl[3]  = '{1024, 1024, 0,  0, 1, 1, 0};
        tbl[4]  = '{1047, 1047, 0,  0, 1, 1, 0};
        tbl[5]  = '{1048, 1048, 0,  0, 0, 1, 0};
        tbl[6]  = '{1183, 1183, 0,  0, 0, 1, 0};
        tbl[7]  = '{1184, 1184, 0,  0, 1, 1, 0};
        tbl[8]  = '{1343, 1343, 0,  0, 1, 1, 0};
        tbl[9]  = '{1344, 0,    1,  1, 1, 1, 0};
        tbl[10] = '{2367, 1023, 1,  1, 1, 1, 0};
        tbl[11] = '{2688, 0,    2,  1, 1, 1, 0};
        tbl[12] = '{3188, 500,  2,  1, 1, 1, 0};

        rst_x = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_x("x_reset", 1343, 805, 0, 1, 1, 0);
        chk("s_reset_hcnt", int'(s_h), 15);
        chk("s_reset_vcnt", int'(s_v), 9);
        chk("s_reset_de", int'(s_de), 0);
        chk("s_reset_flash", int'(s_fl), 0);

        rst_x = 1'b0;
        idx = 0; de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int c = 0; c <= 3188; c++) begin
            @(negedge clk);
            if (c < 1344) begin
                if (x_de) de_cnt++;
                if (!x_hs) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(x_h);
                    hs_last = int'(x_h);
                end
            end
            if (idx < 13 && tbl[idx].c == c) begin
                chk_x($sformatf("x_vec%0d", idx), tbl[idx].h, tbl[idx].v,
                      tbl[idx].de, tbl[idx].hs, tbl[idx].vs, tbl[idx].fs);
                idx++;
            end
        end
        chk("x_line_de_clocks", de_cnt, 1024);
        chk("x_line_hsync_clocks", hs_cnt, 136);
        chk("x_hsync_first_hcnt", hs_first, 1048);
        chk("x_hsync_last_hcnt", hs_last, 1183);

        // Mid-frame reset at hcnt=500: counters jump straight to the reset position.
        rst_x = 1'b1;
        @(negedge clk);
        chk_x("x_midreset", 1343, 805, 0, 1, 1, 0);
        @(negedge clk);
        rst_x = 1'b0;
        @(negedge clk);
        chk_x("x_restart0", 0, 0, 1, 1, 1, 1);
        @(negedge clk);
        chk_x("x_restart1", 1, 0, 1, 1, 1, 0);

        // 33 full frames plus a partial one ending at hcnt=5, vcnt=3.
        rst_s = 1'b0;
        run_small("sm_a", 33 * 160 + 54);
        rst_s = 1'b1;
        @(negedge clk);
        chk("s_midreset_hcnt", int'(s_h), 15);
        chk("s_midreset_vcnt", int'(s_v), 9);
        chk("s_midreset_de", int'(s_de), 0);
        chk("s_midreset_hsync", int'(s_hs), 1);
        chk("s_midreset_vsync", int'(s_vs), 1);
        chk("s_midreset_fs", int'(s_fs), 0);
        chk("s_midreset_flash", int'(s_fl), 0);
        @(negedge clk);
        rst_s = 1'b0;
        // After reset the flash divider must restart from zero.
        run_small("sm_b", 17 * 160 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
